// File: rtl/spi_slave_frame_if.sv
// spi_slave_frame_if: SPI pins plus downstream rx/tx handshake for spi_slave_frame.
interface spi_slave_frame_if #(parameter int DATA_W = 8);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              busy;
  logic              frame_err;
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, busy, frame_err
  );
  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave deserialising cmd+payload frames and serialising read data on MISO.
module spi_slave_frame #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst,
  spi_slave_frame_if.slave bus
);
  localparam int F  = DATA_W + 2;
  localparam int CW = $clog2(F + 1);
  typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [F-2:0]      rx_sh_q, rx_sh_d;
  logic [F-1:0]      rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  logic [F-1:0]      frame;
  logic [1:0]        cmd;
  logic              rd_ok;
  assign frame = {rx_sh_q, bus.MOSI};
  assign cmd   = frame[F-1:F-2];
  assign rd_ok = (cmd != 2'b11) || armed_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
    end
  end
  // The first transmit bit is registered on the tx_valid edge; tx_sh keeps the remaining bits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    armed_d    = armed_q;
    tx_sh_d    = tx_sh_q;
    miso_d     = 1'b0;
    if (state_q != IDLE && bus.SS_n) begin
      state_d = IDLE;
      err_d   = state_q != DONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = bus.SS_n ? IDLE : RX;
        end
        RX: begin
          rx_sh_d = frame[F-2:0];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(F - 1)) begin
            err_d      = !rd_ok;
            rx_valid_d = rd_ok;
            rx_data_d  = rd_ok ? frame : rx_data_q;
            armed_d    = cmd == 2'b10 ? 1'b1 : cmd == 2'b11 ? 1'b0 : armed_q;
            state_d    = (cmd == 2'b11 && rd_ok) ? WAIT_TX : DONE;
          end
        end
        WAIT_TX: begin
          if (bus.tx_valid) begin
            miso_d  = LSB_FIRST ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
            tx_sh_d = LSB_FIRST ? bus.tx_data >> 1 : bus.tx_data << 1;
            cnt_d   = '0;
            state_d = TX;
          end
        end
        TX: begin
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_d = DONE;
          end else begin
            miso_d  = LSB_FIRST ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
            tx_sh_d = LSB_FIRST ? tx_sh_q >> 1 : tx_sh_q << 1;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end
  assign bus.MISO      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// tb_spi_slave_frame: directed and random frames on an 8-bit MSB-first and a 16-bit LSB-first slave.
module tb_spi_slave_frame;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_rx [2];
  bit          m_arm [2];
  logic        o_miso, o_rxv, o_err, o_busy;
  logic [31:0] o_rxd;

  spi_slave_frame_if #(.DATA_W(8))  if0 ();
  spi_slave_frame_if #(.DATA_W(16)) if1 ();
  spi_slave_frame #(.DATA_W(8),  .LSB_FIRST(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  spi_slave_frame #(.DATA_W(16), .LSB_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;

  assign if0.SS_n     = sel | ss_n;
  assign if0.MOSI     = mosi;
  assign if0.tx_valid = !sel && tx_valid;
  assign if0.tx_data  = tx_data[7:0];
  assign if1.SS_n     = !sel | ss_n;
  assign if1.MOSI     = mosi;
  assign if1.tx_valid = sel && tx_valid;
  assign if1.tx_data  = tx_data;
  assign o_miso = sel ? if1.MISO      : if0.MISO;
  assign o_rxv  = sel ? if1.rx_valid  : if0.rx_valid;
  assign o_err  = sel ? if1.frame_err : if0.frame_err;
  assign o_busy = sel ? if1.busy      : if0.busy;
  assign o_rxd  = sel ? {14'd0, if1.rx_data} : {22'd0, if0.rx_data};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (dut%0d) t=%0t: got %h expected %h", tag, sel, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset();
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_miso", 32'(o_miso), 0);
    chk("rst_rxd",  o_rxd, 0);
    chk("rst_rxv",  32'(o_rxv), 0);
    chk("rst_err",  32'(o_err), 0);
  endtask

  // nb: MOSI bits before SS_n rises (full frame when nb == F); dly < 0 aborts in WAIT_TX;
  // txbits: bits seen before SS_n abort (DATA_W = complete); rst_now resets after txbits bits.
  task automatic run_frame(input bit s, input logic [1:0] cmd, input logic [15:0] pay, input int nb,
                           input int dly, input logic [15:0] txd, input int txbits, input bit rst_now);
    int          dw, f;
    logic [31:0] frm;
    bit          ok;
    logic        eb;
    dw  = s ? 16 : 8;
    f   = dw + 2;
    frm = (32'(cmd) << dw) | (32'(pay) & ((32'd1 << dw) - 1));
    sel = s;
    ss_n = 1'b0;
    tick();
    chk("busy_start", 32'(o_busy), 1);
    for (int i = 0; i < nb; i++) begin
      mosi = frm[f-1-i];
      tick();
      if (i < f - 1) begin
        chk("rxv_mid", 32'(o_rxv), 0);
        chk("err_mid", 32'(o_err), 0);
      end
    end
    if (nb < f) begin
      ss_n = 1'b1;
      tick();
      chk("err_rx_abort", 32'(o_err), 1);
      chk("busy_rx_abort", 32'(o_busy), 0);
      chk("rxv_rx_abort", 32'(o_rxv), 0);
      chk("rxd_rx_abort", o_rxd, m_rx[s]);
      tick();
      chk("err_once", 32'(o_err), 0);
      return;
    end
    ok = !(cmd == 2'b11 && !m_arm[s]);
    chk("rxv_end", 32'(o_rxv), 32'(ok));
    chk("err_end", 32'(o_err), 32'(!ok));
    if (ok) begin
      m_rx[s] = frm;
      if (cmd == 2'b10) m_arm[s] = 1'b1;
      if (cmd == 2'b11) m_arm[s] = 1'b0;
    end
    chk("rxd_end", o_rxd, m_rx[s]);
    chk("miso_rx", 32'(o_miso), 0);
    if (ok && cmd == 2'b11) begin
      if (dly < 0) begin
        repeat (-dly) begin
          tick();
          chk("miso_wait", 32'(o_miso), 0);
        end
        ss_n = 1'b1;
        tick();
        chk("err_wait_abort", 32'(o_err), 1);
        chk("busy_wait_abort", 32'(o_busy), 0);
        tick();
        return;
      end
      repeat (dly) begin
        tick();
        chk("miso_wait", 32'(o_miso), 0);
        chk("busy_wait", 32'(o_busy), 1);
      end
      tx_valid = 1'b1;
      tx_data  = txd;
      tick();
      tx_valid = 1'b0;
      tx_data  = 16'($urandom);
      for (int i = 0; i < txbits; i++) begin
        eb = s ? txd[i] : txd[dw-1-i];
        chk("miso_bit", 32'(o_miso), 32'(eb));
        if (i < txbits - 1) tick();
      end
      if (rst_now) begin
        rst  = 1'b1;
        ss_n = 1'b1;
        tick();
        m_rx[0] = '0; m_rx[1] = '0; m_arm[0] = 1'b0; m_arm[1] = 1'b0;
        chk_idle_reset();
        rst = 1'b0;
        return;
      end
      if (txbits < dw) begin
        ss_n = 1'b1;
        tick();
        chk("err_tx_abort", 32'(o_err), 1);
        chk("miso_tx_abort", 32'(o_miso), 0);
        chk("busy_tx_abort", 32'(o_busy), 0);
        tick();
        chk("err_once", 32'(o_err), 0);
        return;
      end
      tick();
      chk("miso_tail", 32'(o_miso), 0);
      chk("busy_done", 32'(o_busy), 1);
    end
    repeat ($urandom_range(0, 2)) begin
      mosi = 1'($urandom);
      tick();
      chk("rxv_done", 32'(o_rxv), 0);
      chk("err_done", 32'(o_err), 0);
      chk("busy_done", 32'(o_busy), 1);
    end
    ss_n = 1'b1;
    tick();
    chk("busy_end", 32'(o_busy), 0);
    chk("err_end_done", 32'(o_err), 0);
    chk("rxd_end_done", o_rxd, m_rx[s]);
  endtask

  initial begin
    bit          s;
    int          dw, f, nb, dly, txb;
    logic [1:0]  cmd;
    m_rx[0] = '0; m_rx[1] = '0; m_arm[0] = 1'b0; m_arm[1] = 1'b0;
    repeat (2) tick();
    sel = 1'b0; chk_idle_reset();
    sel = 1'b1; chk_idle_reset();
    rst = 1'b0;
    tick();
    run_frame(0, 2'b00, 16'h00A5, 10, 0, 0, 8, 0);
    chk("wr_addr_val", o_rxd, 32'h0A5);
    run_frame(0, 2'b10, 16'h0003, 10, 0, 0, 8, 0);
    run_frame(0, 2'b11, 16'h005C, 10, 2, 16'h00A5, 8, 0);
    run_frame(0, 2'b11, 16'h0011, 10, 0, 0, 8, 0);
    run_frame(0, 2'b01, 16'h0077, 5, 0, 0, 8, 0);
    run_frame(0, 2'b01, 16'h0077, 10, 0, 0, 8, 0);
    run_frame(0, 2'b10, 16'h0001, 10, 0, 0, 8, 0);
    run_frame(0, 2'b11, 16'h0000, 10, 1, 16'h00C3, 4, 1);
    run_frame(0, 2'b11, 16'h0000, 10, 0, 0, 8, 0);
    run_frame(1, 2'b01, 16'hFFFF, 18, 0, 0, 16, 0);
    chk("dw16_val", o_rxd, 32'h1FFFF);
    run_frame(1, 2'b10, 16'h1234, 18, 0, 0, 16, 0);
    run_frame(1, 2'b11, 16'h0000, 18, 0, 16'h0001, 16, 0);
    run_frame(1, 2'b10, 16'h0042, 18, 0, 0, 16, 0);
    run_frame(1, 2'b11, 16'h0000, 18, 3, 16'hA5A5, 16, 0);
    for (int n = 0; n < 80; n++) begin
      s   = 1'($urandom);
      dw  = s ? 16 : 8;
      f   = dw + 2;
      cmd = 2'($urandom);
      nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, f - 1)) : f;
      dly = ($urandom_range(0, 6) == 0) ? -int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      txb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, dw - 1)) : dw;
      run_frame(s, cmd, 16'($urandom), nb, dly, 16'($urandom), txb, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
